// File: rtl/rr_stream_mux.sv
// rr_stream_mux: NUM_IN-way stream mux, round-robin or forced select.
// Registered output. Optional beat counter: RR_STREAM_MUX_BEAT_CNT_EN.
module rr_stream_mux #(
   parameter int WIDTH  = 4,
   parameter int NUM_IN = 2,
   parameter int SELW   = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
   input  logic                    mode,
   input  logic [SELW-1:0]         sel,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SELW-1:0]         out_sel
`ifdef RR_STREAM_MUX_BEAT_CNT_EN
   ,
   output logic [15:0]             beat_cnt
`endif
);

   logic [SELW-1:0]     ptr;
   logic [SELW-1:0]     grant;
   logic                grant_valid;
   logic [WIDTH-1:0]    grant_data;
   logic                load;
   logic [2*NUM_IN-1:0] rot;

   assign load = ~out_valid | out_ready;

   // rot[k] is the valid of channel (ptr+k) mod NUM_IN; ptr < NUM_IN
   assign rot = {in_valid, in_valid} >> ptr;

   always_comb begin
      int gi;
      gi          = 0;
      grant       = '0;
      grant_valid = 1'b0;
      if (mode) begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SELW'(i) && in_valid[i]) begin
               grant       = SELW'(i);
               grant_valid = 1'b1;
            end
         end
      end else begin
         for (int k = 0; k < NUM_IN; k++) begin
            if (!grant_valid && rot[k]) begin
               gi = int'(ptr) + k;
               if (gi >= NUM_IN)
                  gi = gi - NUM_IN;
               grant       = SELW'(gi);
               grant_valid = 1'b1;
            end
         end
      end
   end

   always_comb begin
      grant_data = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (grant == SELW'(i))
            grant_data = in_data[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < NUM_IN; i++)
         in_ready[i] = load & rst_n & grant_valid & (grant == SELW'(i));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (load) begin
         if (grant_valid) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_sel   <= grant;
            if (!mode)
               ptr <= (int'(grant) == NUM_IN - 1) ? '0 : grant + SELW'(1);
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef RR_STREAM_MUX_BEAT_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         beat_cnt <= '0;
      else if (out_valid && out_ready && beat_cnt != 16'hFFFF)
         beat_cnt <= beat_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: directed + random stimulus against a cycle model.
// Three channels so wrap and out-of-range sel are both reachable.
module tb_rr_stream_mux;

   localparam int W  = 8;
   localparam int N  = 3;
   localparam int SW = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_ready;
   logic           mode;
   logic [SW-1:0]  sel;
   logic [W-1:0]   out_data;
   logic           out_valid;
   logic           out_ready;
   logic [SW-1:0]  out_sel;
`ifdef RR_STREAM_MUX_BEAT_CNT_EN
   logic [15:0]    beat_cnt;
`endif

   rr_stream_mux #(.WIDTH(W), .NUM_IN(N), .SELW(SW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .mode(mode),
      .sel(sel),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sel(out_sel)
`ifdef RR_STREAM_MUX_BEAT_CNT_EN
      ,
      .beat_cnt(beat_cnt)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference state
   bit m_valid;
   bit m_clean;
   int m_data;
   int m_sel;
   int m_ptr;
   int m_cnt;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input logic md,
                               input int s);
      logic [N-1:0] t;
      pick = -1;
      if (md) begin
         t = v >> s;
         if (s < N && t[0])
            pick = s;
      end else begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            t = v >> c;
            if (pick < 0 && t[0])
               pick = c;
         end
      end
   endfunction

   function automatic logic [N*W-1:0] mk(input int b0, input int b1,
                                         input int b2);
      mk = {W'(b2), W'(b1), W'(b0)};
   endfunction

   // called at a negedge; returns at the following negedge
   task automatic cycle(input logic rn, input logic [N-1:0] v,
                        input logic md, input int s, input logic ordy,
                        input logic [N*W-1:0] d);
      int g;
      logic ld;
      logic [N-1:0] er;
      check("out_valid", out_valid, m_valid);
      if (m_valid || m_clean) begin
         check("out_data", out_data, m_data);
         check("out_sel", out_sel, m_sel);
      end
`ifdef RR_STREAM_MUX_BEAT_CNT_EN
      check("beat_cnt", beat_cnt, m_cnt);
`endif
      rst_n = rn; in_valid = v; mode = md;
      sel = SW'(s); out_ready = ordy; in_data = d;
      #1;
      ld = !m_valid || ordy;
      g  = pick(v, md, s);
      er = '0;
      if (rn && ld && g >= 0)
         er = N'(1) << g;
      check("in_ready", in_ready, er);
      @(posedge clk);
      if (!rn)
         m_cnt = 0;
      else if (m_valid && ordy && m_cnt < 65535)
         m_cnt++;
      if (!rn) begin
         m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0; m_clean = 1;
      end else if (ld) begin
         if (g >= 0) begin
            m_valid = 1;
            m_data  = int'((d >> (g * W)) & (N*W)'(8'hFF));
            m_sel   = g;
            m_clean = 0;
            if (!md)
               m_ptr = (g + 1) % N;
         end else begin
            m_valid = 0;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      int seq[3];
      rst_n = 1'b0; in_valid = '0; mode = 1'b0; sel = '0;
      out_ready = 1'b0; in_data = '0;
      repeat (2) @(posedge clk);
      m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0; m_clean = 1; m_cnt = 0;
      @(negedge clk);

      // round-robin, all channels valid
      for (int k = 0; k < 6; k++) begin
         cycle(1, 3'b111, 0, 0, 1, mk(8'h10, 8'h11, 8'h12));
         check("rr_sel", out_sel, k % 3);
         check("rr_data", out_data, 8'h10 + k % 3);
         check("rr_valid", out_valid, 1);
      end

      // sparse with wrap: ptr moved to 1, then ch2, ch0, ch2
      cycle(1, 3'b001, 0, 0, 1, mk(8'h20, 8'h21, 8'h22));
      seq = '{2, 0, 2};
      for (int k = 0; k < 3; k++) begin
         cycle(1, 3'b101, 0, 0, 1, mk(8'h30, 8'h31, 8'h32));
         check("sparse_sel", out_sel, seq[k]);
      end

      // forced select, then out-of-range sel drains and stalls
      for (int k = 0; k < 4; k++) begin
         cycle(1, 3'b111, 1, 2, 1, mk(8'h40 + k, 8'h50 + k, 8'h60 + k));
         check("forced_sel", out_sel, 2);
         check("forced_data", out_data, 8'h60 + k);
      end
      cycle(1, 3'b111, 1, 3, 1, mk(1, 2, 3));
      check("oor_drain", out_valid, 0);
      cycle(1, 3'b111, 1, 3, 1, mk(1, 2, 3));

      // back-pressure holding 8'h42
      cycle(1, 3'b010, 1, 1, 1, mk(0, 8'h42, 0));
      for (int k = 0; k < 3; k++) begin
         cycle(1, 3'b111, 1, 1, 0, mk(0, 8'h55, 0));
         check("bp_hold", out_data, 8'h42);
      end
      cycle(1, 3'b111, 1, 1, 1, mk(0, 8'h55, 0));
      check("bp_next", out_data, 8'h55);
      check("bp_valid", out_valid, 1);

      // reset while a beat is held
      cycle(1, 3'b010, 1, 1, 1, mk(0, 8'hA5, 0));
      cycle(1, 3'b111, 1, 1, 0, mk(0, 8'h77, 0));
      check("pre_rst", out_data, 8'hA5);
      cycle(0, 3'b111, 0, 0, 0, mk(1, 2, 3));
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);

      // random
      for (int k = 0; k < 500; k++) begin
         cycle(($urandom_range(0, 49) != 0), N'($urandom), 1'($urandom),
               int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
               (N*W)'($urandom));
      end

`ifdef RR_STREAM_MUX_BEAT_CNT_EN
      cycle(0, 3'b000, 0, 0, 0, mk(0, 0, 0));
      for (int k = 0; k < 6; k++)
         cycle(1, 3'b111, 0, 0, 1, mk(k, k, k));
      check("cnt_5", beat_cnt, 5);
      for (int k = 0; k < 65540; k++)
         cycle(1, 3'b111, 0, 0, 1, mk(k, k, k));
      check("cnt_sat", beat_cnt, 16'hFFFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised, registered successor to the team's 2:1 bus mux.
- Selects one of NUM_IN input streams, each WIDTH bits wide, and forwards it through a one-stage output register with valid/ready handshakes.
- Two select modes: round-robin arbitration across all valid inputs, or a forced select (the classic mux behaviour).
- Sits between multiple producers and a single shared consumer bus.

Parameters:
- WIDTH, 4: data width per channel in bits (WIDTH >= 1).
- NUM_IN, 2: number of input channels (2..16; need not be a power of 2).
- SELW, 1: width of select/index signals; integrator sets it to at least ceil(log2(NUM_IN)).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_data  input  NUM_IN*WIDTH  flattened inputs; channel i at [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready; at most one bit high per cycle.
- mode  input  1  0 = round-robin, 1 = forced select.
- sel  input  SELW  forced channel index; used only when mode=1.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.
- out_sel  output  SELW  index of the channel that produced out_data.

Behaviour:
- Reset: rst_n=0 sampled at a clk edge clears all state.
  - out_valid=0, out_data=0, out_sel=0, rr pointer=0.
  - in_ready is forced to 0 while rst_n=0.
  - A beat held in the output register when reset is taken is dropped.
- Load enable: load = ~out_valid | out_ready. The register accepts a new beat the same cycle the old one drains, so full throughput is one beat per cycle.
- Grant selection (combinational):
  - mode=0: grant goes to the first i with in_valid[i]=1, searching from ptr upward, modulo NUM_IN.
  - mode=1: grant = sel, only if sel < NUM_IN and in_valid[sel]=1. Otherwise no grant.
  - in_ready[i] = load & rst_n & grant_valid & (grant==i). All other bits are 0.
- Transfer on an input occurs when in_valid[g] & in_ready[g]. On that edge:
  - out_data <= channel g data; out_sel <= g; out_valid <= 1.
  - If mode=0: ptr <= (g==NUM_IN-1) ? 0 : g+1, so the pointer wraps at NUM_IN-1.
  - If mode=1: ptr is unchanged.
- No grant while load=1: out_valid <= 0 if the current beat drained, otherwise it holds.
- Back-pressure: out_valid=1 & out_ready=0 means out_data, out_sel and out_valid all hold and all in_ready=0.
- Latency: one cycle from input handshake to out_valid.
- Simultaneous drain+load: out_valid stays 1 and the data is replaced. There are no bubbles.
- Mode or sel change mid-stream: takes effect at the next grant decision. A beat already held is unaffected.
- Out-of-range sel (sel >= NUM_IN): the input side stalls and the output drains normally.
- Inputs are never reordered. Each accepted beat appears exactly once on the output.

Optional Feature:
- Macro: RR_STREAM_MUX_BEAT_CNT_EN
- With the macro defined:
  - Adds output port beat_cnt, 16 bits.
  - Increments on every out_valid & out_ready cycle and saturates at 16'hFFFF.
  - Reset to 0 by rst_n=0.
- Without the macro: the port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset mid-transfer: NUM_IN=4, WIDTH=8, out_valid=1 holding 8'hA5 with out_ready=0, pulse rst_n=0 for one edge -> out_valid=0, out_data=0, out_sel=0, in_ready=4'b0000 during reset.
- Round-robin fairness: mode=0, all in_valid=4'b1111, data ch i = 8'h10+i, out_ready=1 -> out_sel sequence 0,1,2,3,0,…; out_data 8'h10,11,12,13,10; one beat per cycle after the first.
- Sparse round-robin with wrap: mode=0, in_valid=4'b1001, ptr=1 -> grants ch3 then ch0, then ch3 again; ptr wraps 3->0.
- Forced select and out-of-range: mode=1, sel=2, in_valid=4'b1111 -> only in_ready[2] toggles and out_sel=2 every beat. With NUM_IN=3, sel=3 -> in_ready=0 and the held beat drains.
- Back-pressure: out_ready=0 for 3 cycles with out_valid=1, out_data=8'h42 -> out_data stays 8'h42 and in_ready=0. Release -> 8'h42 transfers, the next beat loads the same edge, and out_valid stays 1.
- Counter (with RR_STREAM_MUX_BEAT_CNT_EN): 5 accepted output beats -> beat_cnt=5. Preload near saturation via 65540 beats -> beat_cnt=16'hFFFF.
